// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one Mux among 2**switch_bits requesters, with bounded hold and a one-cycle gap.
// Optional `define MUXARB_LOCK_EN adds a `lock` input that suppresses the hold-limit release while busy.
module mux_rr_arbiter #(
  parameter int switch_bits = 2,
  parameter int data_width  = 8,
  parameter int hold_width  = 8,
  parameter int HOLD_MAX    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef MUXARB_LOCK_EN
  input  logic                      lock,
`endif
  input  logic [2**switch_bits-1:0] req,
  output logic [2**switch_bits-1:0] gnt,
  output logic [switch_bits-1:0]    sel,
  output logic                      bus_valid,
  output logic [hold_width-1:0]     hold_cnt
);

  localparam int N = 2**switch_bits;
  localparam logic [hold_width-1:0] HOLD_LAST = hold_width'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
  localparam logic [hold_width-1:0] HOLD_SAT  = '1;

  if (data_width < 1 || HOLD_MAX < 0 || HOLD_MAX >= 2**hold_width) begin : g_bad_cfg
    $error("mux_rr_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t                 state_q, state_d;
  logic [N-1:0]           gnt_q, gnt_d;
  logic [switch_bits-1:0] sel_q, sel_d;
  logic                   bus_valid_q, bus_valid_d;
  logic [hold_width-1:0]  hold_cnt_q, hold_cnt_d;
  logic [switch_bits-1:0] ptr_q, ptr_d;

  logic                   win_found;
  logic [switch_bits-1:0] win;
  logic [switch_bits-1:0] idx;
  logic                   hold_hit;
  logic                   release_grant;

  // Scan from the requester just after the last owner, wrapping around once.
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    idx       = '0;
    for (int i = 1; i <= N; i++) begin
      idx = ptr_q + switch_bits'(i);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win       = idx;
      end
    end
  end

  always_comb begin
    hold_hit = (HOLD_MAX != 0) && (hold_cnt_q == HOLD_LAST);
`ifdef MUXARB_LOCK_EN
    hold_hit = hold_hit && !lock;
`endif
    release_grant = !req[sel_q] || hold_hit;
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    bus_valid_d = bus_valid_q;
    hold_cnt_d  = hold_cnt_q;
    ptr_d       = ptr_q;
    case (state_q)
      IDLE, GAP: begin
        if (win_found) begin
          state_d     = BUSY;
          gnt_d       = '0;
          gnt_d[win]  = 1'b1;
          sel_d       = win;
          bus_valid_d = 1'b1;
          hold_cnt_d  = '0;
        end else begin
          state_d     = IDLE;
          gnt_d       = '0;
          bus_valid_d = 1'b0;
          hold_cnt_d  = '0;
        end
      end
      BUSY: begin
        if (release_grant) begin
          state_d     = GAP;
          gnt_d       = '0;
          bus_valid_d = 1'b0;
          hold_cnt_d  = '0;
          ptr_d       = sel_q;
        end else if (hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        bus_valid_d = 1'b0;
        hold_cnt_d  = '0;
      end
    endcase
  end

  // Pointer resets to the last index so requester 0 wins first after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      sel_q       <= '0;
      bus_valid_q <= 1'b0;
      hold_cnt_q  <= '0;
      ptr_q       <= switch_bits'(N - 1);
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      bus_valid_q <= bus_valid_d;
      hold_cnt_q  <= hold_cnt_d;
      ptr_q       <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign bus_valid = bus_valid_q;
  assign hold_cnt  = hold_cnt_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomised and directed checks of mux_rr_arbiter against a cycle-level behavioural model.
module tb_mux_rr_arbiter;

  localparam int SB       = 2;
  localparam int N        = 4;
  localparam int HW       = 8;
  localparam int HOLD_MAX = 4;
  localparam int VW       = N + SB + 1 + HW;
`ifdef MUXARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic          lockIn;
  logic [N-1:0]  gnt;
  logic [SB-1:0] sel;
  logic          bus_valid;
  logic [HW-1:0] hold_cnt;
  logic [VW-1:0] obsVec;

  int checks = 0;
  int errors = 0;

  // Model: owner index, whether the bus is owned or in the gap, and grant age.
  int  mState;
  int  mSel;
  int  mPtr;
  int  mCnt;

  always #5 clk = ~clk;

  mux_rr_arbiter #(
    .switch_bits(SB),
    .data_width (8),
    .hold_width (HW),
    .HOLD_MAX   (HOLD_MAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef MUXARB_LOCK_EN
    .lock     (lockIn),
`endif
    .req      (req),
    .gnt      (gnt),
    .sel      (sel),
    .bus_valid(bus_valid),
    .hold_cnt (hold_cnt)
  );

  assign obsVec = {gnt, sel, bus_valid, hold_cnt};

  function automatic void modelReset();
    mState = 0;
    mSel   = 0;
    mPtr   = N - 1;
    mCnt   = 0;
  endfunction

  function automatic void modelStep(input logic [N-1:0] r, input logic lk);
    int w;
    bit hit;
    if (mState == 1) begin
      hit = (HOLD_MAX != 0) && (mCnt == HOLD_MAX - 1) && !(LOCK_EN && lk);
      if (!r[mSel] || hit) begin
        mState = 2;
        mPtr   = mSel;
        mCnt   = 0;
      end else if (mCnt < (1 << HW) - 1) begin
        mCnt = mCnt + 1;
      end
    end else begin
      w = -1;
      for (int k = 1; k <= N; k++)
        if (w < 0 && r[(mPtr + k) % N]) w = (mPtr + k) % N;
      if (w >= 0) begin
        mState = 1;
        mSel   = w;
        mCnt   = 0;
      end else begin
        mState = 0;
        mCnt   = 0;
      end
    end
  endfunction

  function automatic logic [VW-1:0] expVec();
    logic [N-1:0] g;
    logic         v;
    g = '0;
    v = (mState == 1);
    if (v) g[mSel] = 1'b1;
    return {g, SB'(mSel), v, HW'(mCnt)};
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    modelStep(req, lockIn);
    #1;
  endtask

  task automatic drainToIdle();
    req = '0;
    repeat (3) stepCycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; lockIn = 1'b0;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (obsVec !== '0) begin
      errors++;
      $display("[TB] FAIL reset_async: got %h want %h", obsVec, {VW{1'b0}});
    end
    modelReset();
    #1 rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      stepCycle();
      if (c == 0) begin
        checks++;
        if (gnt !== 4'b0001) begin
          errors++;
          $display("[TB] FAIL reset_first_grant: gnt=%b want 0001", gnt);
        end
      end
      checks++;
      if (obsVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL reset_run cyc %0d: got %h want %h", c, obsVec, expVec());
      end
    end
  endtask

  task automatic test_round_robin();
    req = 4'b1111;
    for (int c = 0; c < 24; c++) begin
      stepCycle();
      checks++;
      if (obsVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL round_robin cyc %0d: got %h want %h", c, obsVec, expVec());
      end
    end
  endtask

  task automatic test_early_release();
    drainToIdle();
    req = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      stepCycle();
      if (c == 1) req = '0;
      checks++;
      if (obsVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL early_release cyc %0d: got %h want %h", c, obsVec, expVec());
      end
    end
    checks++;
    if (sel !== 2'd2 || gnt !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL early_release_idle: sel=%0d gnt=%b want sel=2 gnt=0000", sel, gnt);
    end
  endtask

  task automatic test_pointer_skip();
    drainToIdle();
    req = 4'b0010;
    stepCycle();
    req = '0;
    stepCycle();
    stepCycle();
    req = 4'b1001;
    for (int c = 0; c < 12; c++) begin
      stepCycle();
      if (c == 0) begin
        checks++;
        if (gnt !== 4'b1000 || sel !== 2'd3) begin
          errors++;
          $display("[TB] FAIL pointer_skip_first: gnt=%b sel=%0d want 1000 sel=3", gnt, sel);
        end
      end
      checks++;
      if (obsVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL pointer_skip cyc %0d: got %h want %h", c, obsVec, expVec());
      end
    end
  endtask

  task automatic test_async_reset();
    drainToIdle();
    req = 4'b0100;
    repeat (3) stepCycle();
    checks++;
    if (obsVec !== expVec()) begin
      errors++;
      $display("[TB] FAIL async_reset_pre: got %h want %h", obsVec, expVec());
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (gnt !== '0 || bus_valid !== 1'b0 || hold_cnt !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset_mid: gnt=%b bv=%b cnt=%0d want 0", gnt, bus_valid, hold_cnt);
    end
    modelReset();
    req = 4'b0101;
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      stepCycle();
      if (c == 0) begin
        checks++;
        if (gnt !== 4'b0001) begin
          errors++;
          $display("[TB] FAIL async_reset_regrant: gnt=%b want 0001", gnt);
        end
      end
      checks++;
      if (obsVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL async_reset_run cyc %0d: got %h want %h", c, obsVec, expVec());
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, N - 1 + N * 0 + (1 << N) - N));
      if ($urandom_range(0, 7) == 0) lockIn = 1'($urandom_range(0, 1));
      stepCycle();
      checks++;
      if (obsVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL random cyc %0d: req=%b got %h want %h", c, req, obsVec, expVec());
      end
    end
    lockIn = 1'b0;
  endtask

`ifdef MUXARB_LOCK_EN
  task automatic test_lock();
    drainToIdle();
    lockIn = 1'b1;
    req = 4'b0010;
    for (int c = 0; c < 13; c++) begin
      stepCycle();
      if (c == 9) begin
        checks++;
        if (gnt !== 4'b0010 || hold_cnt !== 8'd9) begin
          errors++;
          $display("[TB] FAIL lock_hold: gnt=%b cnt=%0d want 0010 cnt=9", gnt, hold_cnt);
        end
        req = '0;
      end
      checks++;
      if (obsVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL lock cyc %0d: got %h want %h", c, obsVec, expVec());
      end
    end
    lockIn = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_early_release();
    test_pointer_skip();
    test_async_reset();
    test_random();
`ifdef MUXARB_LOCK_EN
    test_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one n-way Mux (shared datapath bus) among 2**switch_bits requesters.
- Produces the Mux select `sel`, a one-hot grant `gnt` and a `bus_valid` qualifier.
- Enforces a bounded hold time per grant and a one-cycle turnaround gap between owners.
- Sits between the neuron/processing units that raise requests and the Mux they share.

Parameters:
- switch_bits, 2, select width. N = 2**switch_bits requesters.
- data_width, 8, width of the muxed data. Documentation only; the arbiter carries no data.
- hold_width, 8, width of the hold counter.
- HOLD_MAX, 4, maximum consecutive grant cycles. 0 = unlimited; must be < 2**hold_width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  N  request per requester, level-sensitive.
- gnt  output  N  one-hot grant, registered.
- sel  output  switch_bits  index of the current or last owner; drives Mux q.
- bus_valid  output  1  high exactly when gnt is non-zero.
- hold_cnt  output  hold_width  cycles elapsed in the current grant; debug/visibility.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-low.
- Reset (rst=0), immediately and without a clock edge:
  - state=IDLE, gnt=0, sel=0, bus_valid=0, hold_cnt=0.
  - Round-robin pointer ptr=N-1, so requester 0 has top priority after reset.
- States: IDLE, BUSY, GAP. All outputs are registered.
- Arbitration function (used in IDLE and GAP):
  - Scan req starting at index (ptr+1) mod N, wrapping, and pick the first set bit w.
  - If no bit is set, stay in or return to IDLE.
- IDLE:
  - If req != 0, next cycle: state=BUSY, gnt=1<<w, sel=w, bus_valid=1, hold_cnt=0.
  - Latency from req sampled to gnt visible is 1 clock.
- BUSY: release when req[sel]=0 OR (HOLD_MAX != 0 AND hold_cnt == HOLD_MAX-1).
  - On release: next cycle state=GAP, gnt=0, bus_valid=0, ptr=sel. sel keeps its value; hold_cnt clears to 0.
  - Otherwise hold_cnt increments by 1 and gnt, sel and bus_valid hold.
  - hold_cnt saturates at all-ones when HOLD_MAX=0; no wrap.
- GAP: exactly one dead cycle. Arbitration is evaluated in this cycle.
  - If a winner exists, next cycle is BUSY with the new grant.
  - Otherwise next cycle is IDLE.
  - Result: back-to-back owners are separated by exactly 1 idle cycle.
- Minimum grant length is 1 cycle: if the owner drops req in the first grant cycle, release happens at the next edge.
- Requests arriving or dropping for non-owners during BUSY are ignored until the next arbitration.
- A single requester holding req continuously with HOLD_MAX=4 sees 4 grant cycles, 1 GAP, then is re-granted, because it is the only candidate.
- gnt is always one-hot or zero. sel is always < N.
- Reset asserted mid-grant: gnt and bus_valid drop asynchronously, and ptr returns to N-1.
- Reset release is applied at a clock edge; no arbitration takes place in the cycle reset is released.

Optional Feature:
- Macro: MUXARB_LOCK_EN.
- Defined:
  - Adds input port `lock` (1 bit).
  - While in BUSY with lock=1, the hold-limit release condition is suppressed and only req[sel]=0 releases.
  - hold_cnt still counts and saturates.
  - lock is ignored in IDLE and GAP.
- Undefined:
  - No lock port.
  - The hold limit always applies as described above.

Test Plan:
- Reset: drive rst=0 with req=1111 (switch_bits=2) → gnt=0, sel=0, bus_valid=0 with no clock. Release rst → gnt=0001, sel=0 one edge after the first sampled edge.
- Round robin: req=1111 held, HOLD_MAX=4 → gnt sequence 0001×4, 0000, 0010×4, 0000, 0100×4, 0000, 1000×4, 0000, 0001… with sel=0,1,2,3,0.
- Early release: only req[2] set, dropped after 2 grant cycles → gnt=0100 for exactly 2 cycles, then one GAP cycle, then IDLE with gnt=0 and sel=2.
- Pointer skip: after requester 1 finishes (ptr=1), req=1001 → next grant is 1000 (sel=3), then 0001.
- Async reset mid-grant: assert rst=0 while gnt=0100 in BUSY with hold_cnt=2 → gnt=0, bus_valid=0, hold_cnt=0 before the next edge. After release with req=0101 → gnt=0001 first.
- Lock (MUXARB_LOCK_EN): HOLD_MAX=4, req[1] held for 10 cycles with lock=1 → gnt=0010 continuously for 10 cycles, hold_cnt reaches 9, then GAP. The same stimulus with lock=0 → 4-cycle grants separated by gaps.
